btn_led_ctrl: RTL
=================

// Module: btn_led_ctrl
// PURPOSE
//   Button-driven LED mode controller. Synchronises and debounces the raw
//   pushbutton (active-high, pull-down), classifies presses as short/long,
//   sequences a 2-bit LED mode (OFF/ON/SLOW/FAST) and drives the LED pin.
//   Sits between the button input pin and the board LED in top-level designs.
// PARAMETERS
//   DEBOUNCE_CYCLES    16000     consecutive stable samples to accept a new level (>=2)
//   LONG_PRESS_CYCLES  8000000   debounced hold time that makes a long press (>=2)
//   SLOW_HALF          4000000   LED half-period in SLOW mode, cycles (>=1)
//   FAST_HALF          1000000   LED half-period in FAST mode, cycles (>=1)
// PORTS
//   CLK    in   1  system clock; all state on rising edge
//   RST_N  in   1  asynchronous, active-low reset
//   BTN    in   1  raw pushbutton, 1 = pressed; asynchronous to CLK
//   LED    out  1  LED drive, registered
//   MODE   out  2  current mode: 0 OFF, 1 ON, 2 SLOW, 3 FAST
//   PRESS  out  1  one-cycle pulse on accepted short press
//   LONG   out  1  one-cycle pulse when a press reaches long-press time
// BEHAVIOUR
//   Reset: every flop clears on RST_N low; LED=0, MODE=0, PRESS=0, LONG=0,
//     btn_db=0, FSM=IDLE. Reset mid-press aborts it; no pulse is emitted.
//   Sync: two-flop synchroniser, BTN -> btn_sync, 2-edge latency.
//   Debounce: cnt increments each edge btn_sync!=btn_db, clears to 0 on any edge
//     they match. Edge where differing count reaches DEBOUNCE_CYCLES:
//     btn_db<=btn_sync, cnt<=0. A clean BTN step changes btn_db exactly
//     2+DEBOUNCE_CYCLES edges later; a glitch shorter than DEBOUNCE_CYCLES
//     samples never changes btn_db.
//   Press FSM (states IDLE, DOWN, HELD; hold counter hcnt):
//     IDLE: btn_db=1 -> DOWN, hcnt<=0.
//     DOWN: btn_db=0 -> IDLE, PRESS=1 for that edge's cycle.
//           else hcnt++; when hcnt==LONG_PRESS_CYCLES-1 -> HELD, LONG=1.
//     HELD: btn_db=0 -> IDLE, no pulse (release after long press is silent).
//     PRESS and LONG never assert in the same cycle.
//   Button held through reset release: btn_db rises after debounce -> new press.
//   Mode sequencing, updated on the same edge the pulse asserts:
//     PRESS: MODE<=MODE+1, wrapping 3->0.
//     LONG:  MODE<=0 (OFF), whatever the current mode.
//   Blink: counters sc (0..SLOW_HALF-1) and fc (0..FAST_HALF-1) free-run and
//     wrap; on wrap, phase slow_ph/fast_ph toggles. Any MODE change zeroes both
//     counters and sets both phases to 1, so blink modes start with LED lit.
//     Counter/phase widths: $clog2 of the parameter; no overflow beyond wrap.
//   LED: registered, one edge after MODE/phase:
//     OFF->0, ON->1, SLOW->slow_ph, FAST->fast_ph.
//   End-to-end: BTN release of a short press -> btn_db falls 2+DEBOUNCE_CYCLES
//     edges later -> PRESS/MODE next edge -> LED next edge.
// TESTING (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, SLOW_HALF=8, FAST_HALF=2)
//   1 Reset: RST_N=0 mid-run, BTN=1 -> LED,MODE,PRESS,LONG all 0 with no clock edge.
//   2 Short press: BTN high 30 cycles, then low -> PRESS pulse 7 edges after
//     release, MODE 0->1 same edge, LED=1 one edge later; LONG never asserted.
//   3 Bounce: BTN high 3 cycles, low 1, high 3, low -> btn_db stays 0, no PRESS,
//     MODE unchanged.
//   4 Wrap: four clean short presses -> MODE 1,2,3,0; PRESS exactly once each.
//   5 Long press: MODE=2, BTN held 40 cycles -> LONG one cycle, MODE=0, LED=0;
//     release produces no PRESS.
//   6 Blink: MODE=3 -> LED period 4 cycles (2 high, 2 low), first high on entry;
//     MODE=2 -> 8 high / 8 low.

Source files
------------

// File: rtl/btn_led_ctrl.sv
// Button-driven LED mode controller: synchronise and debounce a raw pushbutton,
// classify presses as short/long, step a 2-bit mode and drive the LED from it.
module btn_led_ctrl #(
    parameter int DEBOUNCE_CYCLES   = 16000,
    parameter int LONG_PRESS_CYCLES = 8000000,
    parameter int SLOW_HALF         = 4000000,
    parameter int FAST_HALF         = 1000000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       BTN,
    output logic       LED,
    output logic [1:0] MODE,
    output logic       PRESS,
    output logic       LONG
);

    // Counters never hold their terminal count, so $clog2 of the parameter is enough.
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW = $clog2(LONG_PRESS_CYCLES);
    localparam int SW = (SLOW_HALF > 1) ? $clog2(SLOW_HALF) : 1;
    localparam int FW = (FAST_HALF > 1) ? $clog2(FAST_HALF) : 1;

    typedef enum logic [1:0] {IDLE, DOWN, HELD} state_e;

    logic          sync1_q, sync2_q;
    logic [DW-1:0] db_cnt_q, db_cnt_d;
    logic          btn_db_q, btn_db_d;
    state_e        state_q, state_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic          press_q, press_d;
    logic          long_q, long_d;
    logic [1:0]    mode_q, mode_d;
    logic [SW-1:0] sc_q, sc_d;
    logic [FW-1:0] fc_q, fc_d;
    logic          slow_ph_q, slow_ph_d;
    logic          fast_ph_q, fast_ph_d;
    logic          led_q, led_d;
    logic          mode_chg;

    // Two-flop synchroniser for the asynchronous button pin.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= BTN;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: accept the new level on the Nth consecutive differing sample.
    always_comb begin
        db_cnt_d = '0;
        btn_db_d = btn_db_q;
        if (sync2_q != btn_db_q) begin
            if (db_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
                btn_db_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    // Press FSM next state; release from DOWN is a short press, reaching the
    // hold limit is a long press, release from HELD is silent.
    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        press_d = 1'b0;
        long_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (btn_db_q) begin
                    state_d = DOWN;
                    hcnt_d  = '0;
                end
            end
            DOWN: begin
                if (!btn_db_q) begin
                    state_d = IDLE;
                    press_d = 1'b1;
                end else if (hcnt_q == HW'(LONG_PRESS_CYCLES - 1)) begin
                    state_d = HELD;
                    long_d  = 1'b1;
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!btn_db_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Mode sequencing and blink generators; a mode change restarts both
    // blinkers with the LED lit.
    always_comb begin
        mode_d = mode_q;
        if (long_d)       mode_d = 2'd0;
        else if (press_d) mode_d = mode_q + 2'd1;
        mode_chg = (mode_d != mode_q);

        sc_d      = sc_q + 1'b1;
        slow_ph_d = slow_ph_q;
        fc_d      = fc_q + 1'b1;
        fast_ph_d = fast_ph_q;
        if (mode_chg) begin
            sc_d      = '0;
            slow_ph_d = 1'b1;
            fc_d      = '0;
            fast_ph_d = 1'b1;
        end else begin
            if (sc_q == SW'(SLOW_HALF - 1)) begin
                sc_d      = '0;
                slow_ph_d = ~slow_ph_q;
            end
            if (fc_q == FW'(FAST_HALF - 1)) begin
                fc_d      = '0;
                fast_ph_d = ~fast_ph_q;
            end
        end

        unique case (mode_q)
            2'd0:    led_d = 1'b0;
            2'd1:    led_d = 1'b1;
            2'd2:    led_d = slow_ph_q;
            default: led_d = fast_ph_q;
        endcase
    end

    // State registers for debounce, FSM, mode, blink and outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            db_cnt_q  <= '0;
            btn_db_q  <= 1'b0;
            state_q   <= IDLE;
            hcnt_q    <= '0;
            press_q   <= 1'b0;
            long_q    <= 1'b0;
            mode_q    <= 2'd0;
            sc_q      <= '0;
            fc_q      <= '0;
            slow_ph_q <= 1'b0;
            fast_ph_q <= 1'b0;
            led_q     <= 1'b0;
        end else begin
            db_cnt_q  <= db_cnt_d;
            btn_db_q  <= btn_db_d;
            state_q   <= state_d;
            hcnt_q    <= hcnt_d;
            press_q   <= press_d;
            long_q    <= long_d;
            mode_q    <= mode_d;
            sc_q      <= sc_d;
            fc_q      <= fc_d;
            slow_ph_q <= slow_ph_d;
            fast_ph_q <= fast_ph_d;
            led_q     <= led_d;
        end
    end

    assign LED   = led_q;
    assign MODE  = mode_q;
    assign PRESS = press_q;
    assign LONG  = long_q;

endmodule
